// File: rtl/rv32_isa.sv
// RV32 ISA constants and types shared by the instruction encoder.
package rv32_isa;

    localparam int unsigned RegWidth     = 32;
    localparam int unsigned RegAddrWidth = 5;

    // Instruction formats; encodings 6 and 7 are undefined.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } ins_fmt_t;

    // addi x0, x0, 0
    localparam logic [RegWidth-1:0] InsNop = 32'h00000013;

    // Payload carried through both pipeline stages.
    typedef struct packed {
        logic                err;
        logic [RegWidth-1:0] ins;
    } enc_word_t;

    localparam int unsigned EncWordWidth = $bits(enc_word_t);

    // True when v[31:lsb] are all equal, i.e. v is representable as a
    // sign-extended value with lsb+1 significant bits.
    function automatic logic imm_fits(input logic [RegWidth-1:0] v, input int unsigned lsb);
        logic [RegWidth-1:0] hi;
        hi = RegWidth'($signed(v) >>> lsb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// One valid/ready register slice with full-throughput ready.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready_c,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Slot can take a word when empty or when its current word leaves this cycle.
    assign in_ready_c = ~out_valid | out_ready;

    // Load on accept, drop valid on drain with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/encoder.sv
// RV32I instruction encoder: checks and packs fields, two-stage valid/ready pipeline.
module encoder
    import rv32_isa::*;
#(
    parameter bit CHECK_IMM = 1'b1
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iValid,
    output logic                    oReady,
    input  ins_fmt_t                iFmt,
    input  logic [6:0]              iOpCode,
    input  logic [2:0]              iFunc3,
    input  logic [6:0]              iFunc7,
    input  logic [RegAddrWidth-1:0] iRD,
    input  logic [RegAddrWidth-1:0] iRS1,
    input  logic [RegAddrWidth-1:0] iRS2,
    input  logic [RegWidth-1:0]     iImm,
    output logic                    oValid,
    input  logic                    iReady,
    output logic [RegWidth-1:0]     oINS,
    output logic                    oErr
);

    logic [RegWidth-1:0] packed_word;
    logic                imm_bad;
    logic                fmt_bad;
    enc_word_t           s1_d;
    enc_word_t           s1_q;
    enc_word_t           s2_q;
    logic                s1_valid;
    logic                s2_ready;

    // Pack fields by format and detect immediates that cannot be encoded.
    always_comb begin
        packed_word = '0;
        imm_bad     = 1'b0;
        fmt_bad     = 1'b0;
        case (iFmt)
            FMT_R: begin
                packed_word = {iFunc7, iRS2, iRS1, iFunc3, iRD, iOpCode};
            end
            FMT_I: begin
                packed_word = {iImm[11:0], iRS1, iFunc3, iRD, iOpCode};
                imm_bad     = ~imm_fits(iImm, 11);
            end
            FMT_S: begin
                packed_word = {iImm[11:5], iRS2, iRS1, iFunc3, iImm[4:0], iOpCode};
                imm_bad     = ~imm_fits(iImm, 11);
            end
            FMT_B: begin
                packed_word = {iImm[12], iImm[10:5], iRS2, iRS1, iFunc3,
                               iImm[4:1], iImm[11], iOpCode};
                imm_bad     = ~imm_fits(iImm, 12) | iImm[0];
            end
            FMT_U: begin
                packed_word = {iImm[31:12], iRD, iOpCode};
                imm_bad     = |iImm[11:0];
            end
            FMT_J: begin
                packed_word = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRD, iOpCode};
                imm_bad     = ~imm_fits(iImm, 20) | iImm[0];
            end
            default: begin
                // Undefined format has no layout to pack into.
                fmt_bad = 1'b1;
            end
        endcase
    end

    // Rejected requests still occupy a slot, carrying a NOP.
    always_comb begin
        s1_d.err = fmt_bad | (CHECK_IMM & imm_bad);
        s1_d.ins = s1_d.err ? InsNop : packed_word;
    end

    pipe_reg #(.W(EncWordWidth)) u_stage1 (
        .clk        (iClk),
        .rst        (iRst),
        .in_valid   (iValid),
        .in_ready_c (oReady),
        .in_data    (s1_d),
        .out_valid  (s1_valid),
        .out_ready  (s2_ready),
        .out_data   (s1_q)
    );

    pipe_reg #(.W(EncWordWidth)) u_stage2 (
        .clk        (iClk),
        .rst        (iRst),
        .in_valid   (s1_valid),
        .in_ready_c (s2_ready),
        .in_data    (s1_q),
        .out_valid  (oValid),
        .out_ready  (iReady),
        .out_data   (s2_q)
    );

    assign oINS = s2_q.ins;
    assign oErr = s2_q.err;

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the encoder: directed cases plus randomized traffic.
module tb_encoder;
    import rv32_isa::*;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    ins_fmt_t    iFmt;
    logic [6:0]  iOpCode;
    logic [2:0]  iFunc3;
    logic [6:0]  iFunc7;
    logic [4:0]  iRD;
    logic [4:0]  iRS1;
    logic [4:0]  iRS2;
    logic [31:0] iImm;
    logic        oValid;
    logic        iReady;
    logic [31:0] oINS;
    logic        oErr;

    int checks = 0;
    int errors = 0;
    logic [32:0] expq[$];
    bit fi;
    bit got;

    encoder #(.CHECK_IMM(1'b1)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iFmt(iFmt), .iOpCode(iOpCode), .iFunc3(iFunc3), .iFunc7(iFunc7),
        .iRD(iRD), .iRS1(iRS1), .iRS2(iRS2), .iImm(iImm),
        .oValid(oValid), .iReady(iReady), .oINS(oINS), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: expected {err, word} from the ISA field layout and immediate ranges.
    function automatic logic [32:0] ref_word(input ins_fmt_t fmt, input logic [6:0] op,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [31:0] imm);
        int s;
        bit ok;
        logic [31:0] w;
        logic [31:0] common;
        s = $signed(imm);
        ok = 1'b1;
        common = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (fmt)
            FMT_R: w = (32'(f7) << 25) | (32'(rs2) << 20) | common | (32'(rd) << 7);
            FMT_I: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = ((imm & 32'hFFF) << 20) | common | (32'(rd) << 7);
            end
            FMT_S: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | common
                     | ((imm & 32'h1F) << 7);
            end
            FMT_B: begin
                ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
                w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (32'(rs2) << 20) | common | (((imm >> 1) & 32'hF) << 8)
                     | (((imm >> 11) & 32'h1) << 7);
            end
            FMT_U: begin
                ok = (imm % 4096) == 0;
                w  = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            end
            FMT_J: begin
                ok = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
                w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                     | (32'(rd) << 7) | 32'(op);
            end
            default: begin
                ok = 1'b0;
                w  = 32'h0;
            end
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h00000013};
    endfunction

    task automatic drv(input ins_fmt_t fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
        iValid = 1'b1; iFmt = fmt; iOpCode = op; iFunc3 = f3; iFunc7 = f7;
        iRD = rd; iRS1 = rs1; iRS2 = rs2; iImm = imm;
    endtask

    // One clock: check the output against the model, track handshakes, advance.
    task automatic cycle(output bit accepted);
        @(negedge iClk);
        accepted = iValid && oReady;
        if (oValid) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed %h expected none", {oErr, oINS});
            end
            if (expq.size() != 0) begin
                chk("word_order", {oErr, oINS}, expq[0]);
                if (iReady) void'(expq.pop_front());
            end
        end
        if (accepted) expq.push_back(ref_word(iFmt, iOpCode, iFunc3, iFunc7, iRD, iRS1, iRS2, iImm));
        @(posedge iClk);
        #1;
    endtask

    // Single word with iReady=1: latency two edges after presentation, then a fixed word.
    task automatic run_one(input string tag, input ins_fmt_t fmt, input logic [6:0] op,
                           input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm, input logic [32:0] exp);
        bit a;
        iReady = 1'b1;
        drv(fmt, op, f3, 7'd0, rd, rs1, rs2, imm);
        cycle(a);
        chk({tag, "_accept"}, 33'(a), 33'd1);
        iValid = 1'b0;
        chk({tag, "_lat1"}, 33'(oValid), 33'd0);
        cycle(a);
        chk({tag, "_lat2"}, 33'(oValid), 33'd1);
        chk({tag, "_word"}, {oErr, oINS}, exp);
        cycle(a);
        chk({tag, "_gone"}, 33'(oValid), 33'd0);
    endtask

    function automatic logic [31:0] gen_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r = {{20{r[11]}}, r[11:0]};
            1: r = {{19{r[12]}}, r[12:1], 1'b0};
            2: r = {{11{r[20]}}, r[20:1], 1'b0};
            3: r = {r[31:12], 12'h000};
            4: r = {{19{r[12]}}, r[12:0]};
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        iRst = 1'b1; iValid = 1'b0; iReady = 1'b1; iFmt = FMT_R; iOpCode = '0;
        iFunc3 = '0; iFunc7 = '0; iRD = '0; iRS1 = '0; iRS2 = '0; iImm = '0;
        #12;
        chk("rst_ovalid", 33'(oValid), 33'd0);
        chk("rst_oready", 33'(oReady), 33'd1);
        chk("rst_oins", 33'(oINS), 33'd0);
        chk("rst_oerr", 33'(oErr), 33'd0);
        @(posedge iClk); #1;
        iRst = 1'b0;
        chk("post_rst_oready", 33'(oReady), 33'd1);
        cycle(fi);

        run_one("i_addi", FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, {1'b0, 32'h00500093});
        run_one("s_sw", FMT_S, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8, {1'b0, 32'h0020A423});
        run_one("u_lui", FMT_U, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, {1'b0, 32'h123452B7});
        run_one("j_jal", FMT_J, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, {1'b0, 32'hFFDFF0EF});
        run_one("b_odd", FMT_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, {1'b1, 32'h00000013});
        run_one("i_range", FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, {1'b1, 32'h00000013});
        run_one("u_low", FMT_U, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, {1'b1, 32'h00000013});
        run_one("fmt_bad", ins_fmt_t'(3'd6), 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0, {1'b1, 32'h00000013});

        // Three back-to-back words with a stalled sink.
        iReady = 1'b0;
        drv(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        cycle(fi); chk("bb_a_accept", 33'(fi), 33'd1);
        drv(FMT_I, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        cycle(fi); chk("bb_b_accept", 33'(fi), 33'd1);
        drv(FMT_I, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
        chk("bb_oready_full", 33'(oReady), 33'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(fi);
            chk("bb_c_blocked", 33'(fi), 33'd0);
            chk("bb_a_held", {oErr, oINS}, {1'b0, 32'h00100093});
        end
        iReady = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle(fi);
            if (fi) got = 1'b1;
        end
        iValid = 1'b0;
        chk("bb_c_accepted", 33'(got), 33'd1);
        for (int k = 0; k < 10 && expq.size() != 0; k++) cycle(fi);
        chk("bb_drained", 33'(expq.size()), 33'd0);

        // Full-rate streaming with an always-ready sink.
        iReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drv(FMT_R, 7'h33, 3'(k), 7'h20, 5'(k), 5'(k + 1), 5'(k + 2), 32'd0);
            cycle(fi);
            chk("stream_accept", 33'(fi), 33'd1);
        end
        iValid = 1'b0;
        for (int k = 0; k < 10 && expq.size() != 0; k++) cycle(fi);
        chk("stream_drained", 33'(expq.size()), 33'd0);

        // Reset with both stages full.
        iReady = 1'b0;
        drv(FMT_I, 7'h13, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd7);
        cycle(fi);
        drv(FMT_I, 7'h13, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'd8);
        cycle(fi);
        iValid = 1'b0;
        chk("full_ovalid", 33'(oValid), 33'd1);
        chk("full_oready", 33'(oReady), 33'd0);
        #2;
        iRst = 1'b1;
        #1;
        chk("mid_rst_ovalid", 33'(oValid), 33'd0);
        chk("mid_rst_oready", 33'(oReady), 33'd1);
        chk("mid_rst_oins", {oErr, oINS}, 33'd0);
        expq.delete();
        @(posedge iClk); #1;
        iRst = 1'b0;
        iReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(fi);
            chk("after_rst_idle", 33'(oValid), 33'd0);
        end
        run_one("after_rst", FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, {1'b0, 32'h00500093});

        // Randomized traffic and backpressure against the reference.
        for (int k = 0; k < 600; k++) begin
            if (!iValid && $urandom_range(0, 3) != 0) begin
                drv(ins_fmt_t'(3'($urandom_range(0, 7))), 7'($urandom), 3'($urandom),
                    7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), gen_imm());
            end
            iReady = ($urandom_range(0, 3) != 0);
            cycle(fi);
            if (fi) iValid = 1'b0;
        end
        iValid = 1'b0;
        iReady = 1'b1;
        for (int k = 0; k < 10 && expq.size() != 0; k++) cycle(fi);
        chk("rand_drained", 33'(expq.size()), 33'd0);
        chk("rand_idle", 33'(oValid), 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
